mem_responder: RTL



---
 rtl/mem_responder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Function : byte-addressable memory with masked writes, extended reads,
//            one-cycle registered read data and sticky access-error flags.
// Revision : 1.0
// ============================================================================
module mem_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter     INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write_mem,
    input  logic [2:0]  funct3,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic [31:0] read_address,
    output logic [31:0] read_data,
    output logic        err_misaligned,
    output logic        err_range,
    output logic        err_funct
);

    localparam int c_AW = $clog2(DEPTH_WORDS);

    logic [31:0]     r_mem [DEPTH_WORDS];
    logic [31:0]     r_read_data;
    logic            r_err_misaligned;
    logic            r_err_range;
    logic            r_err_funct;

    logic [c_AW-1:0] w_widx;
    logic [c_AW-1:0] w_ridx;
    logic            w_wr_range_bad;
    logic            w_rd_range_bad;
    logic            w_wr_size_ok;
    logic            w_wr_align_ok;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic            w_wr_ok;
    logic            w_wr_ef;
    logic            w_wr_er;
    logic            w_wr_em;
    logic            w_we;
    logic            w_rd_size_ok;
    logic            w_rd_align_ok;
    logic            w_rd_ok;
    logic            w_rd_ef;
    logic            w_rd_er;
    logic            w_rd_em;
    logic            w_fwd;
    logic [31:0]     w_merged;
    logic [31:0]     w_shift;
    logic [31:0]     w_rd_val;

    assign w_widx         = write_address[c_AW+1:2];
    assign w_ridx         = read_address[c_AW+1:2];
    assign w_wr_range_bad = |write_address[31:c_AW+2];
    assign w_rd_range_bad = |read_address[31:c_AW+2];

    always_comb begin
        w_wr_size_ok  = 1'b1;
        w_wr_align_ok = 1'b1;
        w_be          = 4'b0000;
        w_wdata       = write_data;
        case (funct3)
            3'b000: begin
                w_be    = 4'b0001 << write_address[1:0];
                w_wdata = {4{write_data[7:0]}};
            end
            3'b001: begin
                w_be          = write_address[1] ? 4'b1100 : 4'b0011;
                w_wdata       = {2{write_data[15:0]}};
                w_wr_align_ok = ~write_address[0];
            end
            3'b010: begin
                w_be          = 4'b1111;
                w_wr_align_ok = (write_address[1:0] == 2'b00);
            end
            default: w_wr_size_ok = 1'b0;
        endcase
    end

    // Error priority: illegal funct3, then out-of-range, then misaligned.
    assign w_wr_ef = write_mem & ~w_wr_size_ok;
    assign w_wr_er = write_mem & w_wr_size_ok & w_wr_range_bad;
    assign w_wr_em = write_mem & w_wr_size_ok & ~w_wr_range_bad & ~w_wr_align_ok;
    assign w_wr_ok = write_mem & w_wr_size_ok & ~w_wr_range_bad & w_wr_align_ok;
    assign w_we    = w_wr_ok & rst_n;

    always_comb begin
        w_rd_size_ok  = 1'b1;
        w_rd_align_ok = 1'b1;
        case (funct3)
            3'b000, 3'b100: w_rd_align_ok = 1'b1;
            3'b001, 3'b101: w_rd_align_ok = ~read_address[0];
            3'b010:         w_rd_align_ok = (read_address[1:0] == 2'b00);
            default:        w_rd_size_ok  = 1'b0;
        endcase
    end

    assign w_rd_ef = ~w_rd_size_ok;
    assign w_rd_er = w_rd_size_ok & w_rd_range_bad;
    assign w_rd_em = w_rd_size_ok & ~w_rd_range_bad & ~w_rd_align_ok;
    assign w_rd_ok = w_rd_size_ok & ~w_rd_range_bad & w_rd_align_ok;

    // Write-first: lanes written this cycle are forwarded into the read word.
    assign w_fwd = w_wr_ok & (w_widx == w_ridx);

    always_comb begin
        w_merged = r_mem[w_ridx];
        for (int i = 0; i < 4; i++) begin
            if (w_fwd && w_be[i]) w_merged[8*i +: 8] = w_wdata[8*i +: 8];
        end
    end

    assign w_shift = w_merged >> {read_address[1:0], 3'b000};

    always_comb begin
        w_rd_val = 32'h0;
        if (w_rd_ok) begin
            case (funct3)
                3'b000:  w_rd_val = {{24{w_shift[7]}}, w_shift[7:0]};
                3'b001:  w_rd_val = {{16{w_shift[15]}}, w_shift[15:0]};
                3'b010:  w_rd_val = w_merged;
                3'b100:  w_rd_val = {24'h0, w_shift[7:0]};
                3'b101:  w_rd_val = {16'h0, w_shift[15:0]};
                default: w_rd_val = 32'h0;
            endcase
        end
    end

    // Storage is never reset; only the write strobe is gated by rst_n.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_widx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_data      <= 32'h0;
            r_err_misaligned <= 1'b0;
            r_err_range      <= 1'b0;
            r_err_funct      <= 1'b0;
        end else begin
            r_read_data      <= w_rd_val;
            r_err_misaligned <= r_err_misaligned | w_rd_em | w_wr_em;
            r_err_range      <= r_err_range | w_rd_er | w_wr_er;
            r_err_funct      <= r_err_funct | w_rd_ef | w_wr_ef;
        end
    end

    assign read_data      = r_read_data;
    assign err_misaligned = r_err_misaligned;
    assign err_range      = r_err_range;
    assign err_funct      = r_err_funct;

endmodule
`default_nettype wire
